// File: rtl/enum_token_accum_pkg.sv
// Shared types for the enum token accumulator: op/state enums, token layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// TOKEN_W derives from PARAM. PARAM is a 32-bit int, so $bits(PARAM) - 32
// is zero and the default gives 86 + 4 = 90 bits.
// Token layout, MSB first: op[2:0] | rsvd[TOKEN_W-36:0] | data[31:0].
package enum_token_accum_pkg;

  localparam int PARAM   = 4;
  localparam int TOKEN_W = $bits(PARAM) - 32 + 86 + PARAM;

  // Command opcodes. Codes 5..7 are illegal: they are treated as NOP and
  // raise the sticky error flag.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_CLR   = 3'd3,
    OP_FLUSH = 3'd4
  } op_e;

  // Controller states. This is a 2-state type, so the unused code 3
  // cannot hold an X; it is recovered to S_IDLE.
  typedef enum bit [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [TOKEN_W-36:0]   rsvd;
    int                    data;
  } token_fields_t;

  typedef union packed {
    bit [TOKEN_W-1:0] raw;
    token_fields_t    f;
  } token_t;

endpackage

// File: rtl/enum_token_alu.sv
// Signed 32-bit add/subtract of a token operand into the running accumulator.
// Latency: combinational, 0 cycles.
// Backpressure: none; the result is a pure function of the inputs.
//
// Ports:
//   acc  - current accumulator value (signed int)
//   data - token operand (signed int)
//   sub  - 1: acc - data, 0: acc + data
//   res  - result: wraps by default, or clamps when ENUM_TOKEN_ACCUM_SAT_EN
//          is defined
module enum_token_alu
  import enum_token_accum_pkg::*;
(
  input  int   acc,
  input  int   data,
  input  logic sub,
  output int   res
);

  // Sign-extend both operands to 33 bits. A signed overflow shows up as
  // bit 32 disagreeing with bit 31.
  logic [32:0] acc_x;
  logic [32:0] data_x;
  logic [32:0] sum_x;

  assign acc_x  = {acc[31], acc};
  assign data_x = {data[31], data};
  assign sum_x  = sub ? (acc_x - data_x) : (acc_x + data_x);

`ifdef ENUM_TOKEN_ACCUM_SAT_EN
  logic ovf;

  assign ovf = sum_x[32] ^ sum_x[31];

  // On overflow, bit 32 holds the true sign of the result.
  always_comb begin
    res = sum_x[31:0];
    if (ovf) begin
      res = sum_x[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  logic carry_unused;

  // Two's-complement wrap: the carry/extension bit is discarded.
  assign res          = sum_x[31:0];
  assign carry_unused = sum_x[32];
`endif

endmodule

// File: rtl/enum_token_accum.sv
// Accumulates signed ADD/SUB command tokens and emits {result, count} on flush or limit.
// Latency: 1 cycle from the FLUSH (or limit-reaching) token transfer to out_valid.
// Backpressure: in_ready is low while a result is held; the result holds until out_ready.
//
// Optional feature: define ENUM_TOKEN_ACCUM_SAT_EN for saturating arithmetic
// instead of wrap-around.
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   in_valid/in_ready    - token handshake; in_ready depends only on state
//   in_token             - TOKEN_W-bit token {op, rsvd, data}
//   o, out_count         - registered result and ADD/SUB count; stable while out_valid
//   out_valid/out_ready  - result handshake
//   err                  - sticky illegal-opcode flag; cleared only by rst
module enum_token_accum
  import enum_token_accum_pkg::*;
#(
  parameter int PARAM      = 4,
  parameter int MAX_TOKENS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOKEN_W-1:0] in_token,
  output int                 o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_count,
  output logic               err
);

  // The module parameter must describe the same token width as the package.
  localparam int TOKEN_W_LOCAL = $bits(PARAM) - 32 + 86 + PARAM;

  generate
    if ((TOKEN_W_LOCAL != TOKEN_W) || ($bits(token_t) != TOKEN_W)) begin : g_bad_width
      $error("enum_token_accum: PARAM does not match enum_token_accum_pkg::PARAM");
    end
    if ((MAX_TOKENS < 1) || (MAX_TOKENS > 255)) begin : g_bad_max
      $error("enum_token_accum: MAX_TOKENS must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] MAX_CNT = MAX_TOKENS[7:0];

  state_e     state;
  int         acc;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  token_t     tok;
  int         alu_res;
  logic       rsvd_unused;

  assign tok      = in_token;
  assign cnt_inc  = cnt + 8'd1;
  assign in_ready = (state != S_OUT);

  // The reserved field is don't-care. It is reduced into a named sink so
  // that ignoring it is an explicit choice.
  assign rsvd_unused = ^tok.f.rsvd;

  enum_token_alu u_alu (
    .acc  (acc),
    .data (tok.f.data),
    .sub  (tok.f.op == OP_SUB),
    .res  (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= 0;
      cnt       <= 8'd0;
      o         <= 0;
      out_valid <= 1'b0;
      out_count <= 8'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          if (in_valid) begin
            case (tok.f.op)
              OP_NOP: ;
              OP_ADD, OP_SUB: begin
                acc <= alu_res;
                cnt <= cnt_inc;
                // Auto-flush: the token that reaches the limit is included
                // in the emitted result.
                if (cnt_inc == MAX_CNT) begin
                  state     <= S_OUT;
                  o         <= alu_res;
                  out_count <= cnt_inc;
                  out_valid <= 1'b1;
                end else begin
                  state <= S_ACC;
                end
              end
              OP_CLR: begin
                acc   <= 0;
                cnt   <= 8'd0;
                state <= S_IDLE;
              end
              OP_FLUSH: begin
                state     <= S_OUT;
                o         <= acc;
                out_count <= cnt;
                out_valid <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_OUT: begin
          // o and out_count hold until the consumer takes the result.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= 0;
            cnt       <= 8'd0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/enum_token_accum.md
Name: enum_token_accum

Overview:
- Downstream consumer of 90-bit enum-typed command tokens.
- Each token is a packed union of a raw vector and a {op, reserved, data} struct; this block accepts tokens over a valid/ready handshake.
- Decodes the op enum and accumulates the signed 32-bit data into an int result.
- Emits the result and the accepted-token count on an output handshake when flushed or when the count limit is reached.
- Also exercises enum bases (logic[2:0], bit[1:0], int), a parametrised width, and $bits in a synthesizable sequential context.

Parameters:
PARAM, 4, token width control; TOKEN_W = $bits(PARAM) - 32 + 86 + PARAM (90 at default)
MAX_TOKENS, 8, auto-flush after this many accumulating tokens; legal range 1..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  token valid
in_ready  output  1  block can accept a token
in_token  input  TOKEN_W  token; op = [TOKEN_W-1 -: 3], reserved = [TOKEN_W-4:32] (ignored), data = [31:0] signed
o  output  32 (int)  accumulated result; stable while out_valid
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_count  output  8  number of ADD/SUB tokens folded into o
err  output  1  sticky: an illegal op code was received

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: o=0, out_valid=0, out_count=0, err=0, internal acc=0, cnt=0, state=S_IDLE; in_ready=1 in the first cycle after reset.
- Op enum, op_e, enum logic[2:0]:
  - OP_NOP=3'd0, OP_ADD=3'd1, OP_SUB=3'd2, OP_CLR=3'd3, OP_FLUSH=3'd4.
  - Codes 5..7 are illegal.
- State enum, state_e, enum bit[1:0]: S_IDLE=0, S_ACC=1, S_OUT=2.
- Transfer rule: a token transfers on a clk edge with in_valid && in_ready. in_ready = (state != S_OUT), combinational from state only, never from in_valid.
- Per accepted token:
  - NOP: no change.
  - ADD: acc += data; cnt++.
  - SUB: acc -= data; cnt++.
  - CLR: acc=0, cnt=0, state -> S_IDLE.
  - FLUSH: state -> S_OUT.
  - Illegal code: treated as NOP; err set to 1 and held until rst.
- Arithmetic: 32-bit two's-complement with wrap-around; the carry is discarded. Example: 32'h7FFF_FFFF + 1 = 32'h8000_0000.
- State transitions:
  - S_IDLE -> S_ACC on the first ADD/SUB.
  - S_ACC -> S_OUT on FLUSH, or when the ADD/SUB that makes cnt == MAX_TOKENS is accepted (auto-flush; that token is included).
  - S_IDLE + FLUSH -> S_OUT with o=0, out_count=0.
- Output timing: entering S_OUT registers o=acc and out_count=cnt, and sets out_valid=1 on the same edge. Latency is 1 cycle from the FLUSH/auto-flush transfer to out_valid.
- S_OUT hold: o and out_count are held stable until out_valid && out_ready.
- Leaving S_OUT: on the output transfer edge, out_valid=0, acc=0, cnt=0, state=S_IDLE, and in_ready=1 in the next cycle.
- out_ready asserted in the same cycle out_valid rises is legal; the output transfer completes on the next edge (min 1 cycle in S_OUT). No input is accepted in that cycle.
- rst asserted mid-operation (any state, including S_OUT with out_valid=1): all outputs return to reset values at the next edge and any pending result is discarded.
- Reserved bits: ignored, with no effect on any output.

Optional Feature:
- Macro: ENUM_TOKEN_ACCUM_SAT_EN.
- Defined: ADD/SUB saturate to 32'h7FFF_FFFF / 32'h8000_0000 instead of wrapping; saturation does not set err.
- Undefined: wrap-around as specified above.
- No port changes either way.

Decomposition:
- Package enum_token_accum_pkg holds:
  - op_e and state_e;
  - token_fields_t, packed struct {op_e op; logic[TOKEN_W-36:0] rsvd; int data};
  - token_t, packed union {bit[TOKEN_W-1:0] raw; token_fields_t f};
  - localparam TOKEN_W.
- PARAM is set in the package; the module parameter must match it, checked with an elaboration-time $bits(token_t)==TOKEN_W assertion.
- One sub-module, enum_token_alu: combinational acc ± data with the optional saturation.

Test Plan:
- Reset then ADD 5, ADD 7, SUB 2, FLUSH with out_ready=1 -> out_valid 1 cycle after FLUSH; o=10, out_count=3; in_ready=1 after the transfer.
- MAX_TOKENS=8, eight ADD 1 with no FLUSH -> auto-flush; o=8, out_count=8; in_ready=0 while out_valid is held for 5 cycles with out_ready=0, and o is stable throughout.
- ADD 32'h7FFF_FFFF, ADD 1, FLUSH:
  - without macro -> o=32'h8000_0000;
  - with ENUM_TOKEN_ACCUM_SAT_EN -> o=32'h7FFF_FFFF; err=0 in both builds.
- Op code 3'd6, then ADD 3, FLUSH -> err=1 from the cycle after the op-6 transfer until rst; o=3, out_count=1.
- ADD 9, CLR, FLUSH -> o=0, out_count=0; also FLUSH straight from reset -> o=0, out_count=0.
- rst pulsed while out_valid=1 (o=10) -> next cycle out_valid=0, o=0, err=0, in_ready=1; a following FLUSH yields o=0.
